risc16_core: RTL and testbench

Single-cycle 16-bit RiSC-16 processor datapath: fetches nothing itself. It takes the current instruction word from an external instruction source addressed by `o_pc`, executes it in one clock, and updates the PC and an 8×16 register file. Data accesses go to an external word-addressed data memory with combinational read and clocked write. It is the top-level compute block of the single-cycle design.

---
 rtl/risc16_pkg.sv | 33 +++
 rtl/risc16_regfile.sv | 32 +++
 rtl/risc16_core.sv | 75 +++++++
 tb/tb_risc16_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// Shared RiSC-16 definitions: opcodes, instruction field positions and the
// immediate sign-extension helper.
package risc16_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned NUM_REGS = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 13;
  localparam int unsigned RA_MSB    = 12;
  localparam int unsigned RA_LSB    = 10;
  localparam int unsigned RB_MSB    = 9;
  localparam int unsigned RB_LSB    = 7;
  localparam int unsigned RC_MSB    = 2;
  localparam int unsigned RC_LSB    = 0;
  localparam int unsigned IMM7_MSB  = 6;
  localparam int unsigned IMM10_MSB = 9;

  function automatic logic [WORD_W-1:0] sext7(input logic [6:0] imm);
    return {{9{imm[6]}}, imm};
  endfunction

endpackage

// File: rtl/risc16_regfile.sv
// 8x16 register file: two asynchronous read ports, one clocked write port,
// r0 reads as zero and ignores writes.
module risc16_regfile
  import risc16_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rd1_addr_i,
  output logic [WORD_W-1:0] rd1_data_o,
  input  logic [REG_AW-1:0] rd2_addr_i,
  output logic [WORD_W-1:0] rd2_data_o,
  input  logic              wr_en_i,
  input  logic [REG_AW-1:0] wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i
);

  logic [WORD_W-1:0] reg_file [0:NUM_REGS-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_file[i] <= '0;
      end
    end else if (wr_en_i && (wr_addr_i != '0)) begin
      reg_file[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd1_data_o = (rd1_addr_i == '0) ? '0 : reg_file[rd1_addr_i];
  assign rd2_data_o = (rd2_addr_i == '0) ? '0 : reg_file[rd2_addr_i];

endmodule

// File: rtl/risc16_core.sv
// Single-cycle RiSC-16 datapath: decodes and executes i_inst each clock,
// updating the PC and register file on the rising edge.
module risc16_core
  import risc16_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WORD_W-1:0] i_inst,
  output logic [WORD_W-1:0] o_pc,
  input  logic [WORD_W-1:0] i_mem_rd_data,
  output logic [WORD_W-1:0] o_mem_wr_data,
  output logic [WORD_W-1:0] o_mem_addr,
  output logic              o_mem_wr_en
);

  logic [WORD_W-1:0] pc_q, pc_d, pc_plus1;
  logic [2:0]        op;
  logic [REG_AW-1:0] ra_idx, rb_idx, rc_idx, rd2_addr;
  logic [WORD_W-1:0] simm, rb_val, rd2_val;
  logic [9:0]        imm10;
  logic              rf_we, mem_we;
  logic [WORD_W-1:0] rf_wd;

  assign op       = i_inst[OP_MSB:OP_LSB];
  assign ra_idx   = i_inst[RA_MSB:RA_LSB];
  assign rb_idx   = i_inst[RB_MSB:RB_LSB];
  assign rc_idx   = i_inst[RC_MSB:RC_LSB];
  assign imm10    = i_inst[IMM10_MSB:0];
  assign simm     = sext7(i_inst[IMM7_MSB:0]);
  assign pc_plus1 = pc_q + 16'd1;

  // Second read port serves rC for RRR ops and rA (store data / compare) otherwise.
  assign rd2_addr = ((op == OP_ADD) || (op == OP_NAND)) ? rc_idx : ra_idx;

  risc16_regfile regfile (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .rd1_addr_i (rb_idx),
    .rd1_data_o (rb_val),
    .rd2_addr_i (rd2_addr),
    .rd2_data_o (rd2_val),
    .wr_en_i    (rf_we),
    .wr_addr_i  (ra_idx),
    .wr_data_i  (rf_wd)
  );

  always_comb begin
    pc_d   = pc_plus1;
    rf_we  = 1'b0;
    rf_wd  = '0;
    mem_we = 1'b0;
    unique case (op)
      OP_ADD:  begin rf_we = 1'b1; rf_wd = rb_val + rd2_val;    end
      OP_ADDI: begin rf_we = 1'b1; rf_wd = rb_val + simm;       end
      OP_NAND: begin rf_we = 1'b1; rf_wd = ~(rb_val & rd2_val); end
      OP_LUI:  begin rf_we = 1'b1; rf_wd = {imm10, 6'b0};       end
      OP_SW:   mem_we = 1'b1;
      OP_LW:   begin rf_we = 1'b1; rf_wd = i_mem_rd_data;       end
      OP_BEQ:  if (rd2_val == rb_val) pc_d = pc_plus1 + simm;
      OP_JALR: begin rf_we = 1'b1; rf_wd = pc_plus1; pc_d = rb_val; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign o_pc          = pc_q;
  assign o_mem_addr    = rb_val + simm;
  assign o_mem_wr_data = rd2_val;
  assign o_mem_wr_en   = mem_we & ~i_rst;

endmodule

// File: tb/tb_risc16_core.sv
// Bench for risc16_core: directed vector table, wrap/self-loop/reset sequences,
// then a random instruction stream against an architectural reference model.
module tb_risc16_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] inst = '0;
  logic [15:0] pc, wr_data, addr, rd_data;
  logic        wr_en;

  logic [15:0] dmem [0:65535];
  logic [15:0] mmem [0:65535];
  logic [15:0] r_m [8];
  logic [15:0] pc_m;
  int          checks = 0;
  int          failures = 0;
  int          op_cnt [8];

  typedef struct {
    logic [15:0] inst;
    int unsigned ridx;
    logic [15:0] rval;
    logic [15:0] pc;
  } vec_t;
  vec_t vecs [16];

  always #5 clk = ~clk;

  assign rd_data = dmem[addr];

  risc16_core dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_inst        (inst),
    .o_pc          (pc),
    .i_mem_rd_data (rd_data),
    .o_mem_wr_data (wr_data),
    .o_mem_addr    (addr),
    .o_mem_wr_en   (wr_en)
  );

  function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [2:0] c);
    return {op, a, b, 4'b0, c};
  endfunction

  function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [6:0] imm);
    return {op, a, b, imm};
  endfunction

  function automatic logic [15:0] ri(input logic [2:0] op, input logic [2:0] a,
                                     input logic [9:0] imm);
    return {op, a, imm};
  endfunction

  function automatic logic [15:0] dut_reg(input int i);
    return dut.regfile.reg_file[i];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural reference: one instruction applied to the model state.
  task automatic model_step(input logic [15:0] in);
    int          op, a, b, c;
    logic [15:0] s, ea, nxt, wv;
    bit          wr;
    op  = int'(in[15:13]);
    a   = int'(in[12:10]);
    b   = int'(in[9:7]);
    c   = int'(in[2:0]);
    s   = {{9{in[6]}}, in[6:0]};
    ea  = r_m[b] + s;
    nxt = pc_m + 16'd1;
    wr  = 1'b1;
    wv  = '0;
    case (op)
      0: wv = r_m[b] + r_m[c];
      1: wv = ea;
      2: wv = ~(r_m[b] & r_m[c]);
      3: wv = {in[9:0], 6'b0};
      4: begin mmem[ea] = r_m[a]; wr = 1'b0; end
      5: wv = mmem[ea];
      6: begin wr = 1'b0; if (r_m[a] == r_m[b]) nxt = pc_m + 16'd1 + s; end
      default: begin wv = pc_m + 16'd1; nxt = r_m[b]; end
    endcase
    if (wr && a != 0) r_m[a] = wv;
    pc_m = nxt;
  endtask

  task automatic check_state();
    chk("pc", pc, pc_m);
    for (int i = 1; i < 8; i++) chk($sformatf("r%0d", i), dut_reg(i), r_m[i]);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic exec(input logic [15:0] in);
    logic        we;
    logic [15:0] wa, wd;
    int          op;
    inst = in;
    #1;
    op = int'(in[15:13]);
    op_cnt[op]++;
    chk("pc_out", pc, pc_m);
    chk("mem_wr_en", {15'b0, wr_en}, {15'b0, op == 4});
    chk("mem_addr", addr, r_m[int'(in[9:7])] + {{9{in[6]}}, in[6:0]});
    if (op == 4) chk("mem_wr_data", wr_data, r_m[int'(in[12:10])]);
    we = wr_en;
    wa = addr;
    wd = wr_data;
    model_step(in);
    @(posedge clk);
    if (we) dmem[wa] = wd;
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    inst = rri(3'd4, 3'd1, 3'd0, 7'd5);
    rst  = 1'b1;
    #1;
    chk("rst_wr_en", {15'b0, wr_en}, 16'h0);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    pc_m = '0;
    for (int i = 0; i < 8; i++) r_m[i] = '0;
    check_state();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dmem[i] = '0;
      mmem[i] = '0;
    end
    for (int i = 0; i < 8; i++) op_cnt[i] = 0;

    vecs[0]  = '{rri(3'd1, 3'd1, 3'd0, 7'h7F), 1, 16'hFFFF, 16'h0001};
    vecs[1]  = '{ri(3'd3, 3'd2, 10'h3FF),      2, 16'hFFC0, 16'h0002};
    vecs[2]  = '{rri(3'd1, 3'd2, 3'd2, 7'h3F), 2, 16'hFFFF, 16'h0003};
    vecs[3]  = '{rrr(3'd2, 3'd3, 3'd2, 3'd2),  3, 16'h0000, 16'h0004};
    vecs[4]  = '{ri(3'd3, 3'd6, 10'h048),      6, 16'h1200, 16'h0005};
    vecs[5]  = '{rri(3'd1, 3'd6, 3'd6, 7'h34), 6, 16'h1234, 16'h0006};
    vecs[6]  = '{rrr(3'd0, 3'd0, 3'd2, 3'd2),  0, 16'h0000, 16'h0007};
    vecs[7]  = '{rri(3'd7, 3'd5, 3'd6, 7'h00), 5, 16'h0008, 16'h1234};
    vecs[8]  = '{rri(3'd4, 3'd1, 3'd0, 7'h05), 1, 16'hFFFF, 16'h1235};
    vecs[9]  = '{rri(3'd5, 3'd4, 3'd0, 7'h05), 4, 16'hFFFF, 16'h1236};
    vecs[10] = '{rrr(3'd2, 3'd3, 3'd0, 3'd0),  3, 16'hFFFF, 16'h1237};
    vecs[11] = '{rrr(3'd0, 3'd7, 3'd1, 3'd4),  7, 16'hFFFE, 16'h1238};
    vecs[12] = '{rri(3'd6, 3'd1, 3'd0, 7'h03), 1, 16'hFFFF, 16'h1239};
    vecs[13] = '{rri(3'd6, 3'd0, 3'd0, 7'h03), 0, 16'h0000, 16'h123D};
    vecs[14] = '{rri(3'd7, 3'd6, 3'd6, 7'h00), 6, 16'h123E, 16'h1234};
    vecs[15] = '{rri(3'd1, 3'd7, 3'd7, 7'h40), 7, 16'hFFBE, 16'h1235};

    // Reset state with a store on the instruction bus.
    @(negedge clk);
    inst = rri(3'd4, 3'd1, 3'd0, 7'd5);
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_wr_en", {15'b0, wr_en}, 16'h0);
    do_reset();

    for (int k = 0; k < 16; k++) begin
      exec(vecs[k].inst);
      chk($sformatf("vec%0d_pc", k), pc, vecs[k].pc);
      chk($sformatf("vec%0d_r%0d", k, vecs[k].ridx), dut_reg(int'(vecs[k].ridx)), vecs[k].rval);
    end
    chk("dmem5", dmem[5], 16'hFFFF);

    // PC wrap FFFF -> 0000 via a plain jump.
    do_reset();
    exec(rri(3'd1, 3'd1, 3'd0, 7'h7F));
    exec(rri(3'd7, 3'd0, 3'd1, 7'h00));
    chk("wrap_jump_pc", pc, 16'hFFFF);
    exec(rrr(3'd0, 3'd0, 3'd0, 3'd0));
    chk("wrap_pc", pc, 16'h0000);

    // BEQ self-loop at PC 10.
    do_reset();
    for (int k = 0; k < 10; k++) exec(rrr(3'd0, 3'd0, 3'd0, 3'd0));
    exec(rri(3'd6, 3'd0, 3'd0, 7'h7F));
    exec(rri(3'd6, 3'd0, 3'd0, 7'h7F));
    chk("beq_loop_pc", pc, 16'h000A);

    // Asynchronous reset asserted mid-cycle.
    exec(rri(3'd1, 3'd3, 3'd0, 7'h11));
    inst = rri(3'd4, 3'd3, 3'd0, 7'h09);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 16'h0000);
    chk("async_rst_r3", dut_reg(3), 16'h0000);
    chk("async_rst_wr_en", {15'b0, wr_en}, 16'h0);
    @(negedge clk);
    rst  = 1'b0;
    pc_m = '0;
    for (int i = 0; i < 8; i++) r_m[i] = '0;
    check_state();

    // Random stream; half the time rB=r0 so addresses cluster near zero.
    for (int n = 0; n < 20000; n++) begin
      logic [15:0] ri_w;
      ri_w = 16'($urandom);
      if ($urandom_range(1, 0) == 0) ri_w[9:7] = 3'd0;
      exec(ri_w);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("cov_op%0d", i), {15'b0, op_cnt[i] > 0}, 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
